// File: rtl/prio_enc_arb.sv
// Registered N-input priority encoder with valid/ready output handshake.
// MODE=0 grants the highest set request; MODE=1 rotates priority round-robin.
module prio_enc_arb #(
    parameter int  N    = 8,
    parameter int  MODE = 0,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [W-1:0] ptr;
    logic [W-1:0] sel_idx_p0;
    logic         sel_hit_p0;
    logic         load_p0;
    logic         accept_p0;
    int           p;
    logic [W-1:0] pos;

    assign accept_p0 = valid && ready;
    assign load_p0   = en && (!valid || ready);

    // Stage 0: downward circular search starting at ptr. In MODE=0 ptr never
    // leaves N-1, so the same search yields plain highest-index-wins priority.
    always_comb begin
        sel_hit_p0 = 1'b0;
        sel_idx_p0 = '0;
        p          = 0;
        pos        = '0;
        for (int k = 0; k < N; k++) begin
            p = int'(ptr) - k;
            if (p < 0) p = p + N;
            pos = W'(p);
            if (!sel_hit_p0 && req[pos]) begin
                sel_hit_p0 = 1'b1;
                sel_idx_p0 = pos;
            end
        end
    end

    // Stage 1: output register; selection above always sees the pre-update ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            idx    <= '0;
            onehot <= '0;
            ptr    <= W'(N - 1);
        end else begin
            if (load_p0) begin
                valid  <= sel_hit_p0;
                idx    <= sel_idx_p0;
                onehot <= sel_hit_p0 ? (ONE << sel_idx_p0) : '0;
            end else if (accept_p0) begin
                valid  <= 1'b0;
                onehot <= '0;
            end
            if (MODE != 0 && accept_p0) begin
                ptr <= (idx == '0) ? W'(N - 1) : idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Scoreboard bench for prio_enc_arb: fixed N=8, round-robin N=8 and round-robin N=5
// instances share stimulus; a reference model queues expected outputs per cycle.
module tb_prio_enc_arb;

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ready;
    logic [7:0] req;

    logic       v0, v1, v2;
    logic [2:0] idx0, idx1, idx2;
    logic [7:0] oh0, oh1;
    logic [4:0] oh2;

    int tests  = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int   nn[3] = '{8, 8, 5};
    int   md[3] = '{0, 1, 1};
    logic mv[3] = '{1'b0, 1'b0, 1'b0};
    int   mi[3] = '{0, 0, 0};
    int   mp[3] = '{7, 7, 4};

    always #5 clk = ~clk;

    prio_enc_arb #(.N(8), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
        .valid(v0), .idx(idx0), .onehot(oh0)
    );
    prio_enc_arb #(.N(8), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
        .valid(v1), .idx(idx1), .onehot(oh1)
    );
    prio_enc_arb #(.N(5), .MODE(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .req(req[4:0]), .ready(ready),
        .valid(v2), .idx(idx2), .onehot(oh2)
    );

    function automatic int highest(input int n, input logic [7:0] r);
        int res = -1;
        for (int i = 0; i < n; i++) if (r[i]) res = i;
        return res;
    endfunction

    // First set bit walking down from start, wrapping modulo n.
    function automatic int rr_pick(input int n, input int start, input logic [7:0] r);
        for (int k = 0; k < n; k++) begin
            int i = (start - k + n) % n;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_update();
        logic acc;
        int   g;
        int   optr;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            acc = mv[k] && ready;
            if (rst) begin
                mv[k] = 1'b0;
                mi[k] = 0;
                mp[k] = nn[k] - 1;
            end else begin
                optr = mp[k];
                if (acc && md[k] == 1) mp[k] = (mi[k] == 0) ? nn[k] - 1 : mi[k] - 1;
                if (en && (!mv[k] || ready)) begin
                    g = (md[k] == 1) ? rr_pick(nn[k], optr, req) : highest(nn[k], req);
                    if (g >= 0) begin
                        mv[k] = 1'b1;
                        mi[k] = g;
                    end else begin
                        mv[k] = 1'b0;
                        mi[k] = 0;
                    end
                end else if (acc) begin
                    mv[k] = 1'b0;
                end
            end
            e.v   = mv[k];
            e.idx = 3'(mi[k]);
            e.oh  = mv[k] ? (8'd1 << mi[k]) : 8'd0;
            if (k == 0) q0.push_back(e);
            else if (k == 1) q1.push_back(e);
            else q2.push_back(e);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic e, input logic rd, input logic rs);
        req   = r;
        en    = e;
        ready = rd;
        rst   = rs;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d (%b), want %0d (%b)", nm, got, got, want, want);
        end
    endtask

    task automatic cmp(input string nm, input logic v, input logic [2:0] i,
                       input logic [7:0] oh, input exp_t e);
        tests++;
        if (v !== e.v || i !== e.idx || oh !== e.oh) begin
            errors++;
            $display("FAIL %s @%0t: got v=%b idx=%0d onehot=%b, want v=%b idx=%0d onehot=%b",
                     nm, $time, v, i, oh, e.v, e.idx, e.oh);
        end
    endtask

    // Monitor: one expected entry per instance per clock edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin e = q0.pop_front(); cmp("u0_fixed8", v0, idx0, oh0, e); end
        if (q1.size() > 0) begin e = q1.pop_front(); cmp("u1_rr8", v1, idx1, oh1, e); end
        if (q2.size() > 0) begin e = q2.pop_front(); cmp("u2_rr5", v2, idx2, {3'b000, oh2}, e); end
    end

    initial begin
        logic [7:0] r;
        rst = 1'b1; en = 1'b0; ready = 1'b0; req = 8'h00;
        @(negedge clk);

        // Reset, then empty requests
        step(8'h00, 1'b1, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b1, 1'b1, 1'b0);
            chk("empty_valid", {7'd0, v0}, 8'd0);
            chk("empty_idx", {5'd0, idx0}, 8'd0);
            chk("empty_onehot", oh0, 8'd0);
        end

        // Fixed priority
        step(8'b0101_0010, 1'b1, 1'b1, 1'b0);
        chk("fix_valid", {7'd0, v0}, 8'd1);
        chk("fix_idx6", {5'd0, idx0}, 8'd6);
        chk("fix_onehot6", oh0, 8'b0100_0000);
        step(8'b0000_0011, 1'b1, 1'b1, 1'b0);
        chk("fix_idx1", {5'd0, idx0}, 8'd1);

        // Back-pressure hold
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h80, 1'b1, 1'b0, 1'b0);
        chk("bp_idx7", {5'd0, idx0}, 8'd7);
        for (int i = 0; i < 2; i++) begin
            step(8'h01, 1'b1, 1'b0, 1'b0);
            chk("bp_hold_idx", {5'd0, idx0}, 8'd7);
            chk("bp_hold_onehot", oh0, 8'h80);
        end
        step(8'h01, 1'b1, 1'b1, 1'b0);
        chk("bp_next_valid", {7'd0, v0}, 8'd1);
        chk("bp_next_idx0", {5'd0, idx0}, 8'd0);

        // Round-robin rotation: load, then accept with en low
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1, 1'b1, 1'b0);
            chk("rr_seq_idx", {5'd0, idx1}, 8'((15 - i) % 8));
            step(8'hFF, 1'b0, 1'b1, 1'b0);
            chk("rr_accept_novalid", {7'd0, v1}, 8'd0);
        end

        // Wrap and skip: last accepted was 7, so walk to 0 first
        for (int i = 0; i < 7; i++) begin
            step(8'hFF, 1'b1, 1'b1, 1'b0);
            step(8'hFF, 1'b0, 1'b1, 1'b0);
        end
        step(8'b0000_1001, 1'b1, 1'b1, 1'b0);
        chk("rr_skip_idx3", {5'd0, idx1}, 8'd3);
        step(8'b0000_1001, 1'b0, 1'b1, 1'b0);
        step(8'b0000_1001, 1'b1, 1'b1, 1'b0);
        chk("rr_wrap_idx0", {5'd0, idx1}, 8'd0);

        // en and reset interaction
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h10, 1'b1, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b0, 1'b0);
        chk("en_hold_valid", {7'd0, v0}, 8'd1);
        step(8'h10, 1'b0, 1'b1, 1'b0);
        chk("en_drop_valid", {7'd0, v0}, 8'd0);
        chk("en_drop_onehot", oh0, 8'd0);
        step(8'h10, 1'b1, 1'b0, 1'b0);
        step(8'h10, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", {7'd0, v1}, 8'd0);
        chk("rst_onehot", oh1, 8'd0);
        step(8'hFF, 1'b1, 1'b1, 1'b0);
        chk("post_rst_u1_idx7", {5'd0, idx1}, 8'd7);
        chk("post_rst_u2_idx4", {5'd0, idx2}, 8'd4);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 5) == 0) r = 8'h00;
            else if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            step(r, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) == 0);
        end

        @(posedge clk);
        #2;
        tests++;
        if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d entries left, want 0/0/0",
                     q0.size(), q1.size(), q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
